// File: rtl/tuser_tuple_sequencer_pkg.sv
// Shared types and constants for the TUSER tuple sequencer.
// Holds the FSM state encodings, FIFO sizing and the SUME TUSER port-field layout.
package tuser_seq_pkg;

  typedef enum logic {
    IN_SOP  = 1'b0,
    IN_BODY = 1'b1
  } in_state_t;

  typedef enum logic {
    OUT_SOP  = 1'b0,
    OUT_BODY = 1'b1
  } out_state_t;

  localparam int TUPLE_FIFO_DEPTH_DFLT = 8;
  localparam int TUPLE_FIFO_AW         = $clog2(TUPLE_FIFO_DEPTH_DFLT);

  // SUME TUSER layout: [15:0] length, [23:16] src port, [31:24] dst port
  localparam int TUSER_PORT_W       = 8;
  localparam int TUSER_SRC_PORT_LSB = 16;
  localparam int TUSER_DST_PORT_LSB = 24;

endpackage

// File: rtl/tuser_tuple_sequencer_if.sv
// Stream, tuple and processor handshake signals around the tuple sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface tuser_tuple_sequencer_if #(
  parameter int TW = 128
);

  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [TW-1:0] s_axis_tuser;
  logic          s_axis_tready;
  logic          p4_in_tready;
  logic          tuple_in_valid;
  logic [TW-1:0] tuple_in_data;
  logic          tuple_out_valid;
  logic [TW-1:0] tuple_out_data;
  logic          p4_out_tvalid;
  logic          p4_out_tlast;
  logic          p4_out_tready;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [TW-1:0] m_axis_tuser;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tuser, p4_in_tready,
    input  tuple_out_valid, tuple_out_data, p4_out_tvalid, p4_out_tlast,
    input  m_axis_tready,
    output s_axis_tready, tuple_in_valid, tuple_in_data, p4_out_tready,
    output m_axis_tvalid, m_axis_tuser
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tuser, p4_in_tready,
    output tuple_out_valid, tuple_out_data, p4_out_tvalid, p4_out_tlast,
    output m_axis_tready,
    input  s_axis_tready, tuple_in_valid, tuple_in_data, p4_out_tready,
    input  m_axis_tvalid, m_axis_tuser
  );

endinterface

// File: rtl/tuser_tuple_sequencer_tuple_fifo.sv
// Synchronous FIFO of processor result tuples with a registered head.
// A push into an empty FIFO shows up at the head one cycle later; there is no bypass.
module tuple_fifo
  import tuser_seq_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = TUPLE_FIFO_DEPTH_DFLT
) (
  input  logic         axis_aclk,
  input  logic         axis_resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [LW-1:0] level;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge axis_aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Head reloads from the incoming tuple when it would otherwise become the oldest entry
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (do_push && (empty || (do_pop && level == LW'(1)))) begin
        head <= din;
      end else if (do_pop && level > LW'(1)) begin
        head <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/tuser_tuple_sequencer.sv
// Carries SUME TUSER through the P4 processor: SOP tuser goes out as tuple_in,
// tuple_out results are queued and re-attached to their packet on the egress stream.
module tuser_tuple_sequencer
  import tuser_seq_pkg::*;
#(
  parameter int C_TUSER_WIDTH    = 128,
  parameter int TUPLE_FIFO_DEPTH = TUPLE_FIFO_DEPTH_DFLT,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 axis_aclk,
  input  logic                 axis_resetn,
  tuser_tuple_sequencer_if.slave bus,
  output logic [CNT_WIDTH-1:0] pkt_in_cnt,
  output logic [CNT_WIDTH-1:0] pkt_out_cnt,
  output logic                 err_overflow
);

  in_state_t          in_state;
  in_state_t          in_state_nxt;
  out_state_t         out_state;
  out_state_t         out_state_nxt;
  logic               in_hs;
  logic               tuple_vld;
  logic               m_valid;
  logic               p4_ready;
  logic               out_hs;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [C_TUSER_WIDTH-1:0] fifo_head;

  // Combinational outputs are gated by reset so every output reads 0 while reset is held
  assign in_hs             = axis_resetn & bus.s_axis_tvalid & bus.p4_in_tready;
  assign bus.s_axis_tready = axis_resetn & bus.p4_in_tready;
  assign bus.tuple_in_valid = tuple_vld;
  assign bus.tuple_in_data = axis_resetn ? bus.s_axis_tuser : '0;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) in_state <= IN_SOP;
    else              in_state <= in_state_nxt;
  end

  always_comb begin
    in_state_nxt = in_state;
    tuple_vld    = 1'b0;
    case (in_state)
      IN_SOP: begin
        tuple_vld = in_hs;
        if (in_hs && !bus.s_axis_tlast) in_state_nxt = IN_BODY;
      end
      IN_BODY: begin
        if (in_hs && bus.s_axis_tlast) in_state_nxt = IN_SOP;
      end
      default: in_state_nxt = IN_SOP;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) out_state <= OUT_SOP;
    else              out_state <= out_state_nxt;
  end

  // A packet may only start once its tuple is at the FIFO head; mid-packet beats flow freely
  always_comb begin
    out_state_nxt = out_state;
    m_valid       = 1'b0;
    p4_ready      = 1'b0;
    case (out_state)
      OUT_SOP: begin
        m_valid  = bus.p4_out_tvalid & ~fifo_empty;
        p4_ready = bus.m_axis_tready & ~fifo_empty;
        if (m_valid && bus.m_axis_tready && !bus.p4_out_tlast) out_state_nxt = OUT_BODY;
      end
      OUT_BODY: begin
        m_valid  = bus.p4_out_tvalid;
        p4_ready = bus.m_axis_tready;
        if (m_valid && bus.m_axis_tready && bus.p4_out_tlast) out_state_nxt = OUT_SOP;
      end
      default: out_state_nxt = OUT_SOP;
    endcase
  end

  assign out_hs            = m_valid & bus.m_axis_tready;
  assign fifo_pop          = out_hs & bus.p4_out_tlast;
  assign bus.m_axis_tvalid = m_valid;
  assign bus.p4_out_tready = p4_ready;
  assign bus.m_axis_tuser  = fifo_head;

  tuple_fifo #(
    .W     (C_TUSER_WIDTH),
    .DEPTH (TUPLE_FIFO_DEPTH)
  ) u_tuple_fifo (
    .axis_aclk   (axis_aclk),
    .axis_resetn (axis_resetn),
    .push        (bus.tuple_out_valid),
    .din         (bus.tuple_out_data),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      pkt_in_cnt   <= '0;
      pkt_out_cnt  <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (in_hs && bus.s_axis_tlast) pkt_in_cnt <= pkt_in_cnt + 1'b1;
      if (fifo_pop)                  pkt_out_cnt <= pkt_out_cnt + 1'b1;
      if (bus.tuple_out_valid && fifo_full && !fifo_pop) err_overflow <= 1'b1;
    end
  end

endmodule
